mix_round_sched: RTL and testbench
==================================

// Module: mix_round_sched
// PURPOSE
//  Iterative scheduler for the 8-lane, 32-bit mixing datapath. Each full mixing round is
//  split into single-lane-group phases, and one phase is applied per clock.
//  Seeds are accepted over a valid/ready handshake. The block runs in_iters rounds and
//  returns the 8 lanes over a valid/ready handshake.
//  Sits between the job source and the result consumer. Owns the only lane-state registers.
// PARAMETERS
//  W             32  lane width in bits; all arithmetic is mod 2^W
//  MIX_ROUNDS    3   number of ADDK,CHAIN pairs at round start
//  FOLD_ROUNDS   11  number of FOLD phases
//  SCALE_ROUNDS  5   number of SCALE_A,SCALE_B pairs at round end
//  ITER_W        16  width of in_iters
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active-low
//  in_valid   in   1       seed job offered
//  in_ready   out  1       block can accept a job (state==IDLE)
//  in_data    in   8*W     seed lanes; lane i = in_data[i*W +: W]
//  in_iters   in   ITER_W  number of full rounds to apply
//  out_valid  out  1       result lanes valid (state==DONE)
//  out_ready  in   1       consumer takes the result
//  out_data   out  8*W     working lanes, always driven from the lane registers
//  busy       out  1       state==RUN
// BEHAVIOUR
//  Reset: state=IDLE, lanes=0, phase_idx=0, rounds_left=0, so in_ready=1, out_valid=0, busy=0.
//  Phase sequence, PH_TOTAL = 2*MIX_ROUNDS+3+FOLD_ROUNDS+2*SCALE_ROUNDS (default 30):
//   [ADDK,CHAIN] x MIX_ROUNDS, CROSS, XSHL, SHMIX, FOLD x FOLD_ROUNDS, [SCALE_A,SCALE_B] x SCALE_ROUNDS.
//  Each phase updates lanes 0..7 in order. A lane update reads the already-updated values
//  of lower lanes in the same phase. Indices are taken mod 8.
//   ADDK  o[i]+=i             CHAIN o[i]+=o[i-1]             CROSS o[i]=o[i]+o[i+1]-o[i+5]
//   XSHL  o[i]^=o[i+3]<<16    SHMIX o[i]=o[i]-(o[i+2]>>17)+(o[i+4]>>12)   (logical shifts)
//   FOLD  o[i]=o[i]+o[i-1]-o[i-2]
//   SCALE_A o[i]=o[i]*MA[i]+KA[i]   SCALE_B o[i]=o[i]*MB[i]+KB[i]   (product truncated to W)
//  State machine:
//   IDLE: on in_valid, load lanes<=in_data, phase_idx<=0, rounds_left<=in_iters.
//         If in_iters==0, go to DONE; otherwise go to RUN.
//   RUN:  each cycle apply phase[phase_idx] and increment phase_idx.
//         At phase_idx==PH_TOTAL-1, wrap phase_idx to 0 and decrement rounds_left.
//         If rounds_left was 1, go to DONE.
//   DONE: hold lanes. On out_ready, go to IDLE (no same-cycle accept).
//  Latency: accept at edge t gives out_valid from edge t+1+PH_TOTAL*in_iters.
//  in_valid outside IDLE is ignored. in_data and in_iters are sampled only at accept.
//  out_data is meaningful only while out_valid=1. It changes during RUN.
//  rst_n low at any time (mid-RUN included) aborts the job at once. All regs return to reset values.
//  rounds_left and phase_idx never wrap past their terminal values; ITER_W max gives max rounds.
// STRUCTURE
//  Package mix_sched_pkg contains:
//   phase_e enum {ADDK,CHAIN,CROSS,XSHL,SHMIX,FOLD,SCALE_A,SCALE_B}.
//   Tables MA={2,3,5,7,11,13,17,19}, KA={3,5,7,11,13,17,19,23},
//    MB={2,3,3,3,5,13,35,87}, KB={0,1,8,27,64,125,216,343}.
//   Function phase_of(idx) that maps phase_idx to phase_e.
//  Sub-module mix_phase_unit: purely combinational, (lanes_in, phase_e) -> lanes_out.
//  The top holds the FSM, counters and lane registers.
// TESTING
//  Model: a software 8-lane sequential model is the golden reference for all compares.
//  1 Seed {0..7}, iters=0 -> out_valid 1 cycle after accept, out_data={0,1,2,3,4,5,6,7}.
//  2 Seed all 0, iters=1 -> 2 cycles into RUN out_data={7,8,10,13,17,22,28,35}.
//    out_valid exactly 31 cycles after accept; final lanes bit-exact vs model.
//  3 Seed {0..7}, iters=4 -> busy high 120 cycles, result == model after 4 chained rounds.
//  4 out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0.
//    Extra in_valid pulses are ignored, and the next job is accepted only after the drain.
//  5 rst_n low at RUN phase 12 -> same cycle out_valid=0, busy=0, lanes=0.
//    After release in_ready=1, and the next job matches the model.
//  6 Lanes seeded 32'hFFFF_FFFF, iters=1 -> wrap/truncation bit-exact vs model, no X on outputs.

Source files
------------

// File: rtl/mix_sched_pkg.sv
// Shared types, phase tables and the phase-index decoder for the 8-lane mixing scheduler.
package mix_sched_pkg;

  localparam int unsigned W            = 32;
  localparam int unsigned NLANES       = 8;
  localparam int unsigned MIX_ROUNDS   = 3;
  localparam int unsigned FOLD_ROUNDS  = 11;
  localparam int unsigned SCALE_ROUNDS = 5;
  localparam int unsigned ITER_W       = 16;

  localparam int unsigned PH_TOTAL = 2 * MIX_ROUNDS + 3 + FOLD_ROUNDS + 2 * SCALE_ROUNDS;
  localparam int unsigned PH_W     = $clog2(PH_TOTAL);

  // Phase index boundaries within one round
  localparam int unsigned CROSS_IDX = 2 * MIX_ROUNDS;
  localparam int unsigned XSHL_IDX  = CROSS_IDX + 1;
  localparam int unsigned SHMIX_IDX = CROSS_IDX + 2;
  localparam int unsigned FOLD_END  = SHMIX_IDX + 1 + FOLD_ROUNDS;

  typedef enum logic [2:0] {
    ADDK, CHAIN, CROSS, XSHL, SHMIX, FOLD, SCALE_A, SCALE_B
  } phase_e;

  typedef logic [NLANES-1:0][W-1:0] lanes_t;

  localparam logic [W-1:0] MA [NLANES] = '{2, 3, 5, 7, 11, 13, 17, 19};
  localparam logic [W-1:0] KA [NLANES] = '{3, 5, 7, 11, 13, 17, 19, 23};
  localparam logic [W-1:0] MB [NLANES] = '{2, 3, 3, 3, 5, 13, 35, 87};
  localparam logic [W-1:0] KB [NLANES] = '{0, 1, 8, 27, 64, 125, 216, 343};

  function automatic phase_e phase_of(logic [PH_W-1:0] idx);
    logic [31:0] i;
    logic [31:0] off;
    i   = 32'(idx);
    off = i - FOLD_END;
    if (i < CROSS_IDX) begin
      return i[0] ? CHAIN : ADDK;
    end else if (i == CROSS_IDX) begin
      return CROSS;
    end else if (i == XSHL_IDX) begin
      return XSHL;
    end else if (i == SHMIX_IDX) begin
      return SHMIX;
    end else if (i < FOLD_END) begin
      return FOLD;
    end else begin
      return off[0] ? SCALE_B : SCALE_A;
    end
  endfunction

endpackage

// File: rtl/mix_phase_unit.sv
// Combinational application of one mixing phase to all 8 lanes, lanes updated in order
// so each lane sees the already-updated values of lower lanes.
module mix_phase_unit
  import mix_sched_pkg::*;
(
  input  logic [NLANES*W-1:0] lanes_i,
  input  phase_e              phase_i,
  output logic [NLANES*W-1:0] lanes_o
);

  lanes_t o;

  // Lane index mod 8; negative offsets wrap through two's complement truncation.
  function automatic logic [2:0] lidx(int i);
    return 3'(i);
  endfunction

  always_comb begin
    o = lanes_i;
    for (int i = 0; i < int'(NLANES); i++) begin
      unique case (phase_i)
        ADDK:    o[lidx(i)] = o[lidx(i)] + W'(i);
        CHAIN:   o[lidx(i)] = o[lidx(i)] + o[lidx(i - 1)];
        CROSS:   o[lidx(i)] = o[lidx(i)] + o[lidx(i + 1)] - o[lidx(i + 5)];
        XSHL:    o[lidx(i)] = o[lidx(i)] ^ (o[lidx(i + 3)] << 16);
        SHMIX:   o[lidx(i)] = o[lidx(i)] - (o[lidx(i + 2)] >> 17) + (o[lidx(i + 4)] >> 12);
        FOLD:    o[lidx(i)] = o[lidx(i)] + o[lidx(i - 1)] - o[lidx(i - 2)];
        SCALE_A: o[lidx(i)] = o[lidx(i)] * MA[lidx(i)] + KA[lidx(i)];
        SCALE_B: o[lidx(i)] = o[lidx(i)] * MB[lidx(i)] + KB[lidx(i)];
        default: ;
      endcase
    end
  end

  assign lanes_o = o;

endmodule

// File: rtl/mix_round_sched.sv
// Iterative round scheduler: accepts a seed, applies one mixing phase per clock for
// in_iters full rounds, then presents the lanes until the consumer takes them.
module mix_round_sched
  import mix_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NLANES*W-1:0] in_data,
  input  logic [ITER_W-1:0]   in_iters,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NLANES*W-1:0] out_data,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  lanes_t              lanes_q, lanes_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [ITER_W-1:0]   rounds_q, rounds_d;
  logic [NLANES*W-1:0] lanes_next;

  mix_phase_unit u_phase (
    .lanes_i (lanes_q),
    .phase_i (phase_of(phase_q)),
    .lanes_o (lanes_next)
  );

  always_comb begin
    state_d  = state_q;
    lanes_d  = lanes_q;
    phase_d  = phase_q;
    rounds_d = rounds_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          lanes_d  = in_data;
          phase_d  = '0;
          rounds_d = in_iters;
          state_d  = (in_iters == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        lanes_d = lanes_next;
        if (phase_q == PH_W'(PH_TOTAL - 1)) begin
          phase_d  = '0;
          rounds_d = rounds_q - ITER_W'(1);
          if (rounds_q == ITER_W'(1)) begin
            state_d = StDone;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lanes_q  <= '0;
      phase_q  <= '0;
      rounds_q <= '0;
    end else begin
      state_q  <= state_d;
      lanes_q  <= lanes_d;
      phase_q  <= phase_d;
      rounds_q <= rounds_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun);
  assign out_data  = lanes_q;

endmodule

// File: tb/tb_mix_round_sched.sv
// Directed bench for mix_round_sched with an independent sequential 8-lane reference model.
module tb_mix_round_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [15:0]  in_iters;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] TMA [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
  localparam logic [31:0] TKA [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
  localparam logic [31:0] TMB [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
  localparam logic [31:0] TKB [8] = '{0, 1, 8, 27, 64, 125, 216, 343};

  always #5 clk = ~clk;

  mix_round_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_iters  (in_iters),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] m8(int x);
    return 3'(x);
  endfunction

  // One phase: 0 ADDK, 1 CHAIN, 2 CROSS, 3 XSHL, 4 SHMIX, 5 FOLD, 6 SCALE_A, 7 SCALE_B
  function automatic logic [255:0] step(logic [255:0] s, int ph);
    logic [31:0] v [8];
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = s[i*32 +: 32];
    for (int i = 0; i < 8; i++) begin
      case (ph)
        0: v[i] = v[i] + 32'(i);
        1: v[i] = v[i] + v[m8(i - 1)];
        2: v[i] = v[i] + v[m8(i + 1)] - v[m8(i + 5)];
        3: v[i] = v[i] ^ {v[m8(i + 3)][15:0], 16'h0};
        4: v[i] = v[i] - {17'h0, v[m8(i + 2)][31:17]} + {12'h0, v[m8(i + 4)][31:12]};
        5: v[i] = v[i] + v[m8(i - 1)] - v[m8(i - 2)];
        6: v[i] = v[i] * TMA[i] + TKA[i];
        default: v[i] = v[i] * TMB[i] + TKB[i];
      endcase
    end
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = v[i];
    return r;
  endfunction

  function automatic logic [255:0] model(logic [255:0] seed, int iters);
    logic [255:0] s = seed;
    for (int r = 0; r < iters; r++) begin
      for (int m = 0; m < 3; m++) begin
        s = step(s, 0);
        s = step(s, 1);
      end
      s = step(s, 2);
      s = step(s, 3);
      s = step(s, 4);
      for (int f = 0; f < 11; f++) s = step(s, 5);
      for (int k = 0; k < 5; k++) begin
        s = step(s, 6);
        s = step(s, 7);
      end
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] d, input logic [15:0] it);
    int w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    chk("send_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_iters = it;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output int cyc, output int busy_cyc);
    cyc      = start;
    busy_cyc = 0;
    while (!out_valid && cyc < 2000) begin
      busy_cyc += int'(busy);
      tick();
      cyc++;
    end
    chk("done_timeout", out_valid, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] seq, seq2, seq3, ones, e2, junk, m3;
    int           e2v [8] = '{7, 8, 10, 13, 17, 22, 28, 35};
    int           cyc, bcyc;

    for (int i = 0; i < 8; i++) begin
      seq[i*32 +: 32]  = 32'(i);
      seq2[i*32 +: 32] = 32'h9E37_79B9 * 32'(i + 1);
      seq3[i*32 +: 32] = 32'hDEAD_0000 + 32'(i * 17);
      e2[i*32 +: 32]   = 32'(e2v[i]);
      junk[i*32 +: 32] = 32'h5A5A_0000 + 32'(i);
    end
    ones = '1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_iters  = '0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    tick();

    // iters=0: result is the seed, one cycle after the handshake
    send(seq, 16'd0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, seq);
    drain();
    chk("t1_idle", in_ready, 1'b1);

    // Single round from zero seed
    send('0, 16'd1);
    tick();
    tick();
    chk("t2_busy", busy, 1'b1);
    chk("t2_addk_chain", out_data, e2);
    wait_done(3, cyc, bcyc);
    chk("t2_latency", 256'(cyc), 256'd31);
    chk("t2_data", out_data, model('0, 1));
    drain();

    // Four chained rounds
    send(seq, 16'd4);
    wait_done(1, cyc, bcyc);
    chk("t3_busy_cycles", 256'(bcyc), 256'd120);
    chk("t3_latency", 256'(cyc), 256'd121);
    m3 = model(seq, 4);
    chk("t3_data", out_data, m3);

    // Back-pressure in DONE; in_valid pulses must be ignored
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_data  = junk;
      in_iters = 16'd0;
      tick();
      chk("t4_hold_data", out_data, m3);
      chk("t4_hold_ready", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0;
    drain();
    chk("t4_after_drain", in_ready, 1'b1);
    send(seq2, 16'd0);
    chk("t4_next_job", out_data, seq2);
    drain();

    // Asynchronous reset in the middle of a run
    send(seq2, 16'd2);
    repeat (12) tick();
    chk("t5_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_lanes", out_data, '0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t5_ready", in_ready, 1'b1);
    send(seq3, 16'd1);
    wait_done(1, cyc, bcyc);
    chk("t5_latency", 256'(cyc), 256'd31);
    chk("t5_data", out_data, model(seq3, 1));
    drain();

    // All-ones seed: wrap and truncation
    send(ones, 16'd1);
    wait_done(1, cyc, bcyc);
    chk("t6_data", out_data, model(ones, 1));
    chk("t6_no_x", 256'($isunknown({out_data, out_valid, in_ready, busy})), '0);
    drain();
    chk("t6_idle", in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
